dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-ported, word-addressed data memory (1024 x 32, write on posedge Clk, registered read data one cycle after address) between two requesters: the pipeline MEM stage (port P) and a test/loader engine (port L). P has fixed priority. A starvation counter guarantees L service. Generates the MEM-stage stall and routes the registered read data back to the winning requester.

Parameters:
DEPTH, 1024, memory depth in words; addresses >= DEPTH are out of range
AW, 32, address width (word index, not byte address)
DW, 32, data width
MAX_WAIT, 4, consecutive L losses after which L wins the next contended cycle

Ports:
Clk  input  1  clock, all state on posedge
Rst_n  input  1  asynchronous active-low reset
p_req  input  1  P access request, held until p_gnt
p_we  input  1  P: 1 = store, 0 = load
p_addr  input  AW  P word address
p_wdata  input  DW  P store data
p_gnt  output  1  P request accepted this cycle (combinational)
p_stall  output  1  p_req & ~p_gnt; freezes pipeline
p_rvalid  output  1  P load data valid (registered)
p_rdata  output  DW  P load data
l_req, l_we, l_addr, l_wdata  input  1/1/AW/DW  same meaning for L
l_gnt  output  1  L accepted
l_rvalid  output  1  L load data valid
l_rdata  output  DW  L load data
mem_addr  output  AW  to memory Address
mem_wdata  output  DW  to memory WriteData
mem_we  output  1  to memory MemWrite
mem_re  output  1  to memory MemRead
mem_rdata  input  DW  from memory ReadData
addr_err  output  1  one-cycle pulse: a granted access was out of range

Behaviour:
- Reset (Rst_n=0, async): wait_cnt=0, rd_owner=NONE, p_rvalid=l_rvalid=addr_err=0. Combinational outputs follow inputs with all registered state cleared.
- Grant (combinational, one winner per cycle):
  - only p_req -> P
  - only l_req -> L
  - both -> L if wait_cnt == MAX_WAIT, else P
  - neither -> no grant, mem_we=mem_re=0, mem_addr/mem_wdata=0
- Mux: winner's addr/wdata drive mem_addr/mem_wdata. mem_we = winner_we & in_range. mem_re = ~winner_we & in_range. in_range = addr < DEPTH.
- wait_cnt:
  - l_req & ~l_gnt -> increment, saturating at MAX_WAIT
  - l_gnt or ~l_req -> 0
- rd_owner register, states NONE / P / L, updated every edge:
  - granted load (any range) -> owner = winner
  - otherwise NONE
- Read latency 1: granted load at edge N gives x_rvalid=1 during cycle N+1. x_rdata = mem_rdata when in range, 0 when out of range (registered range flag). Non-owner rdata = 0.
- Stores: written at the grant edge. No rvalid.
- Out-of-range: access is granted (no deadlock). Write is suppressed. addr_err pulses 1 the cycle after.
- Back-to-back: a new grant is allowed every cycle, including load then store to the same address. The load returns the old data, matching memory read-before-write.
- Simultaneous req drop: a requester dropping req without a grant is legal. No state other than wait_cnt changes.
- Reset mid-read: pending rvalid is cancelled; data is never delivered.

Decomposition:
- Shared package dmem_pkg:
  - owner enum (NONE, P, L)
  - DEPTH, AW, DW defaults
- One sub-module: dmem_starve_cnt (saturating wait counter with clear), reusable for future ports.
- Grant/mux logic and owner/rvalid registers stay in the top.

Test Plan:
- Reset: Rst_n=0 mid-load (p load addr 5 granted, reset before next edge) -> p_rvalid stays 0, all registered outputs 0.
- P alone: store addr 993 data 0, then load addr 993 -> p_gnt=1 both cycles, p_stall=0, p_rvalid=1 one cycle later with p_rdata=0.
- Contention: p_req and l_req held continuously, L load addr 10 -> P wins 4 cycles (p_stall=0, l_gnt=0), L granted on the 5th, p_stall=1 that cycle, l_rvalid next cycle, wait_cnt back to 0.
- Read-before-write: L store addr 1023 = -20 granted, next cycle P load 1023 -> p_rdata = -20 (0xFFFFFFEC). Same-cycle ordering: load then store addr 7 -> load returns old value.
- Out of range: P store addr 1024 data 0xDEAD -> p_gnt=1, mem_we=0, addr_err=1 next cycle. Subsequent load addr 1024 -> p_rvalid=1, p_rdata=0, addr_err=1.
- Idle/drop: l_req asserted 2 cycles under contention then dropped -> wait_cnt returns to 0, no l_gnt, no rvalid.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DEPTH_DEF    = 1024;
  localparam int AW_DEF       = 32;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;

  // Which requester owns the read data returning this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

endpackage : dmem_pkg

// File: rtl/dmem_starve_cnt.sv
// Saturating loss counter with synchronous clear; clear wins over increment.
module dmem_starve_cnt #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : dmem_starve_cnt

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported data memory: pipeline port P has fixed
// priority, loader port L is guaranteed service after MAX_WAIT consecutive losses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_stall,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] w_wait_cnt;
  logic          w_l_due;
  logic          w_gnt_p;
  logic          w_gnt_l;
  logic          w_any_gnt;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  logic          w_in_range;
  owner_e        w_owner_nxt;

  owner_e        r_rd_owner;
  logic          r_rd_in_range;
  logic          r_addr_err;

  // L wins a contended cycle only once it has lost MAX_WAIT times in a row.
  assign w_l_due   = (w_wait_cnt == CW'(MAX_WAIT));
  assign w_gnt_p   = p_req & ~(l_req & w_l_due);
  assign w_gnt_l   = l_req & (~p_req | w_l_due);
  assign w_any_gnt = w_gnt_p | w_gnt_l;

  dmem_starve_cnt #(
    .MAX (MAX_WAIT),
    .CW  (CW)
  ) u_l_starve (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .i_inc (l_req & ~w_gnt_l),
    .i_clr (w_gnt_l | ~l_req),
    .o_cnt (w_wait_cnt)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    if (w_gnt_p) begin
      w_win_we    = p_we;
      w_win_addr  = p_addr;
      w_win_wdata = p_wdata;
    end else if (w_gnt_l) begin
      w_win_we    = l_we;
      w_win_addr  = l_addr;
      w_win_wdata = l_wdata;
    end
  end

  assign w_in_range = (w_win_addr < AW'(DEPTH));

  assign p_gnt     = w_gnt_p;
  assign l_gnt     = w_gnt_l;
  assign p_stall   = p_req & ~w_gnt_p;
  assign mem_addr  = w_win_addr;
  assign mem_wdata = w_win_wdata;
  // Out-of-range accesses are still granted so the requester never deadlocks.
  assign mem_we    = w_any_gnt &  w_win_we & w_in_range;
  assign mem_re    = w_any_gnt & ~w_win_we & w_in_range;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_owner    <= OWN_NONE;
      r_rd_in_range <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_rd_owner    <= w_owner_nxt;
      r_rd_in_range <= w_in_range;
      r_addr_err    <= w_any_gnt & ~w_in_range;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_gnt_p && !p_we) begin
      w_owner_nxt = OWN_P;
    end else if (w_gnt_l && !l_we) begin
      w_owner_nxt = OWN_L;
    end
  end

  // Out-of-range loads still complete, but with zero data.
  always_comb begin
    p_rvalid = (r_rd_owner == OWN_P);
    l_rvalid = (r_rd_owner == OWN_L);
    p_rdata  = '0;
    l_rdata  = '0;
    if (p_rvalid && r_rd_in_range) begin
      p_rdata = mem_rdata;
    end
    if (l_rvalid && r_rd_in_range) begin
      l_rdata = mem_rdata;
    end
    addr_err = r_addr_err;
  end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 memory and a
// scoreboard of expected read responses and address-error pulses.
module tb_dmem_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        p_req, p_we, l_req, l_we;
  logic [31:0] p_addr, p_wdata, l_addr, l_wdata;
  logic        p_gnt, p_stall, p_rvalid, l_gnt, l_rvalid;
  logic [31:0] p_rdata, l_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, addr_err;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        p_q[$];
  rsp_t        l_q[$];
  int          err_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        mon_en = 1'b0;
  logic [31:0] mem [1024];

  dmem_arbiter dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_gnt     (p_gnt),
    .p_stall   (p_stall),
    .p_rvalid  (p_rvalid),
    .p_rdata   (p_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .addr_err  (addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model: read-before-write, registered read data.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem_rdata = 32'h5A5A_5A5A;
  end
  always @(posedge Clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle each port either owes a response or must stay quiet.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (p_q.size() > 0 && p_q[0].due == cyc) begin
        check("p_rvalid", {31'b0, p_rvalid}, 32'd1);
        check("p_rdata", p_rdata, p_q[0].data);
        void'(p_q.pop_front());
      end else begin
        check("p_rvalid_quiet", {31'b0, p_rvalid}, 32'd0);
        check("p_rdata_quiet", p_rdata, 32'd0);
      end
      if (l_q.size() > 0 && l_q[0].due == cyc) begin
        check("l_rvalid", {31'b0, l_rvalid}, 32'd1);
        check("l_rdata", l_rdata, l_q[0].data);
        void'(l_q.pop_front());
      end else begin
        check("l_rvalid_quiet", {31'b0, l_rvalid}, 32'd0);
        check("l_rdata_quiet", l_rdata, 32'd0);
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        check("addr_err", {31'b0, addr_err}, 32'd1);
        void'(err_q.pop_front());
      end else begin
        check("addr_err_quiet", {31'b0, addr_err}, 32'd0);
      end
    end
  end

  task automatic set_idle();
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  // One bus cycle: drive, check the combinational grant/mux, cross the edge,
  // then queue the responses the expected winner owes.
  task automatic bus_cycle(
    input logic preq, input logic pwe, input logic [31:0] paddr, input logic [31:0] pwdata,
    input logic lreq, input logic lwe, input logic [31:0] laddr, input logic [31:0] lwdata,
    input logic ep, input logic el, input logic [31:0] erd);
    logic [31:0] wa, wd;
    logic        wwe, inr;
    p_req = preq; p_we = pwe; p_addr = paddr; p_wdata = pwdata;
    l_req = lreq; l_we = lwe; l_addr = laddr; l_wdata = lwdata;
    wa  = ep ? paddr  : (el ? laddr  : 32'd0);
    wd  = ep ? pwdata : (el ? lwdata : 32'd0);
    wwe = ep ? pwe    : (el ? lwe    : 1'b0);
    inr = (wa < 32'd1024);
    #1;
    check("p_gnt",     {31'b0, p_gnt},   {31'b0, ep});
    check("l_gnt",     {31'b0, l_gnt},   {31'b0, el});
    check("p_stall",   {31'b0, p_stall}, {31'b0, preq & ~ep});
    check("mem_addr",  mem_addr, wa);
    check("mem_wdata", mem_wdata, wd);
    check("mem_we",    {31'b0, mem_we},  {31'b0, (ep | el) &  wwe & inr});
    check("mem_re",    {31'b0, mem_re},  {31'b0, (ep | el) & ~wwe & inr});
    @(posedge Clk);
    #1;
    if (ep && !pwe) p_q.push_back('{due: cyc, data: erd});
    if (el && !lwe) l_q.push_back('{due: cyc, data: erd});
    if ((ep || el) && !inr) err_q.push_back(cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_p_rvalid", {31'b0, p_rvalid}, 32'd0);
    check("rst_l_rvalid", {31'b0, l_rvalid}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    check("rst_mem_re",   {31'b0, mem_re},   32'd0);
    Rst_n = 1'b1;

    // Load to addr 5 is granted, but reset lands before the grant edge.
    p_req = 1'b1; p_addr = 32'd5;
    #1;
    check("rstload_p_gnt", {31'b0, p_gnt}, 32'd1);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    set_idle();
    check("rstload_p_rvalid", {31'b0, p_rvalid}, 32'd0);
    @(negedge Clk);
    check("rstload_p_rvalid_neg", {31'b0, p_rvalid}, 32'd0);
    check("rstload_addr_err", {31'b0, addr_err}, 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    mon_en = 1'b1;

    // P alone: store then load addr 993.
    bus_cycle(1, 1, 993, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
    bus_cycle(1, 0, 993, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
    bus_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Contention: P wins 4 times, L load addr 10 wins the 5th.
    for (int i = 0; i < 4; i++)
      bus_cycle(1, 0, 20 + i, 0, 1, 0, 10, 0, 1, 0, 32'hA000_0014 + i);
    bus_cycle(1, 0, 24, 0, 1, 0, 10, 0, 0, 1, 32'hA000_000A);
    // Counter cleared by L's grant, so P wins again.
    bus_cycle(1, 0, 24, 0, 1, 0, 11, 0, 1, 0, 32'hA000_0018);
    bus_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Read-before-write across ports and back-to-back on one port.
    bus_cycle(0, 0, 0, 0, 1, 1, 1023, 32'hFFFF_FFEC, 0, 1, 32'h0);
    bus_cycle(1, 0, 1023, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFEC);
    bus_cycle(0, 0, 0, 0, 1, 0, 1023, 0, 0, 1, 32'hFFFF_FFEC);
    bus_cycle(1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0007);
    bus_cycle(1, 1, 7, 32'h1234_5678, 0, 0, 0, 0, 1, 0, 32'h0);
    bus_cycle(1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);

    // Out of range: store suppressed, load returns zero, both flag addr_err.
    bus_cycle(1, 1, 1024, 32'h0000_DEAD, 0, 0, 0, 0, 1, 0, 32'h0);
    bus_cycle(1, 0, 1024, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    bus_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    bus_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0000);

    // L contends twice then drops; its counter must restart from zero.
    bus_cycle(1, 0, 30, 0, 1, 0, 12, 0, 1, 0, 32'hA000_001E);
    bus_cycle(1, 0, 31, 0, 1, 0, 12, 0, 1, 0, 32'hA000_001F);
    bus_cycle(1, 0, 32, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0020);
    for (int i = 0; i < 4; i++)
      bus_cycle(1, 0, 33 + i, 0, 1, 0, 12, 0, 1, 0, 32'hA000_0021 + i);
    bus_cycle(1, 0, 37, 0, 1, 0, 12, 0, 0, 1, 32'hA000_000C);
    bus_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    bus_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Async reset while a load response is on the bus cancels it at once.
    mon_en = 1'b0;
    p_req = 1'b1; p_addr = 32'd40;
    @(posedge Clk);
    #1;
    set_idle();
    check("midread_p_rvalid", {31'b0, p_rvalid}, 32'd1);
    check("midread_p_rdata",  p_rdata, 32'hA000_0028);
    Rst_n = 1'b0;
    #1;
    check("midread_rst_p_rvalid", {31'b0, p_rvalid}, 32'd0);
    check("midread_rst_p_rdata",  p_rdata, 32'd0);

    check("p_q_drained",   p_q.size(),   32'd0);
    check("l_q_drained",   l_q.size(),   32'd0);
    check("err_q_drained", err_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dmem_arbiter
